// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit.
// Holds access-type encodings, the LSU state encoding and helpers that
// decode an access type into its size and signedness.
package mem_lsu_pkg;

  // data_type_i encodings
  localparam logic [3:0] DT_B  = 4'd0;
  localparam logic [3:0] DT_H  = 4'd1;
  localparam logic [3:0] DT_W  = 4'd2;
  localparam logic [3:0] DT_D  = 4'd3;
  localparam logic [3:0] DT_BU = 4'd4;
  localparam logic [3:0] DT_HU = 4'd5;
  localparam logic [3:0] DT_WU = 4'd6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_t;

  // log2 of the access size in bytes; unknown encodings behave as a word
  function automatic logic [1:0] dt_size_log2(input logic [3:0] dt);
    case (dt)
      DT_B, DT_BU: return 2'd0;
      DT_H, DT_HU: return 2'd1;
      DT_D:        return 2'd3;
      default:     return 2'd2;
    endcase
  endfunction

  function automatic logic dt_is_signed(input logic [3:0] dt);
    return (dt == DT_B) || (dt == DT_H) || (dt == DT_W) || (dt == DT_D);
  endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Lane alignment: store byte-enables and lane-replicated write data, and
// load lane selection with sign/zero extension. Purely combinational.
// Ports: data_type/off select the access; st_data -> st_be/st_wdata; ld_raw -> ld_data.
module lsu_align
  import mem_lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [3:0]                      data_type,
  input  logic [$clog2(DATA_W/8)-1:0]     off,
  input  logic [DATA_W-1:0]               st_data,
  input  logic [DATA_W-1:0]               ld_raw,
  output logic [DATA_W/8-1:0]             st_be,
  output logic [DATA_W-1:0]               st_wdata,
  output logic [DATA_W-1:0]               ld_data
);

  localparam int BE_W = DATA_W / 8;

  logic [DATA_W-1:0] lane;
  logic              sgn;

  always_comb begin
    // the addressed lane is shifted down to bit 0 before extension
    lane     = ld_raw >> {off, 3'b000};
    sgn      = dt_is_signed(data_type);
    st_be    = '1;
    st_wdata = st_data;
    ld_data  = lane;
    case (dt_size_log2(data_type))
      2'd0: begin
        st_be    = BE_W'(1) << off;
        st_wdata = {BE_W{st_data[7:0]}};
        ld_data  = sgn ? DATA_W'($signed(lane[7:0])) : DATA_W'(lane[7:0]);
      end
      2'd1: begin
        st_be    = BE_W'(2'b11) << off;
        st_wdata = {(BE_W/2){st_data[15:0]}};
        ld_data  = sgn ? DATA_W'($signed(lane[15:0])) : DATA_W'(lane[15:0]);
      end
      2'd2: begin
        st_be    = BE_W'(4'hF) << off;
        st_wdata = {(BE_W/4){st_data[31:0]}};
        ld_data  = sgn ? DATA_W'($signed(lane[31:0])) : DATA_W'(lane[31:0]);
      end
      default: begin
        st_be    = '1;
        st_wdata = st_data;
        ld_data  = lane;
      end
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: sized loads/stores over a req/ack bus with
// wait states and timeout; non-memory ops pass straight through.
// Ports: pipeline inputs (valid/flush/rd/ALU/mem controls), bus req/ack
// interface, stall_o to freeze IF..EX, write-back outputs and exceptions.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid_i,
  input  logic                 flush_i,
  input  logic                 ex_w_reg_enable_i,
  input  logic                 mem_w_reg_enable_i,
  input  logic [4:0]           w_reg_addr_i,
  input  logic [DATA_W-1:0]    ex_w_reg_data_i,
  input  logic [ADDR_W-1:0]    mem_addr_i,
  input  logic                 r_mem_enable_i,
  input  logic                 w_mem_enable_i,
  input  logic [DATA_W-1:0]    w_mem_data_i,
  input  logic [3:0]           data_type_i,
  output logic                 bus_req_o,
  output logic                 bus_we_o,
  output logic [ADDR_W-1:0]    bus_addr_o,
  output logic [DATA_W/8-1:0]  bus_be_o,
  output logic [DATA_W-1:0]    bus_wdata_o,
  input  logic                 bus_ack_i,
  input  logic [DATA_W-1:0]    bus_rdata_i,
  input  logic                 bus_err_i,
  output logic                 stall_o,
  output logic                 w_reg_enable_o,
  output logic [4:0]           w_reg_addr_o,
  output logic [DATA_W-1:0]    w_reg_data_o,
  output logic                 exc_misalign_o,
  output logic                 exc_bus_o
);

  localparam int BE_W  = DATA_W / 8;
  localparam int OFF_W = $clog2(BE_W);
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  lsu_state_t          state;
  logic [CNT_W-1:0]    cnt;
  logic                is_load;
  logic                load_wb;
  logic                err;
  logic [4:0]          rd;
  logic [3:0]          dtype;
  logic [OFF_W-1:0]    off;
  logic [DATA_W-1:0]   ld_result;

  logic                mem_op;
  logic                misalign;
  logic                accept;
  logic [3:0]          al_type;
  logic [OFF_W-1:0]    al_off;
  logic [BE_W-1:0]     al_be;
  logic [DATA_W-1:0]   al_wdata;
  logic [DATA_W-1:0]   al_ld;

  assign mem_op = r_mem_enable_i | w_mem_enable_i;

  always_comb begin
    case (dt_size_log2(data_type_i))
      2'd0:    misalign = 1'b0;
      2'd1:    misalign = mem_addr_i[0];
      2'd2:    misalign = |mem_addr_i[1:0];
      // a doubleword cannot be carried by a 32-bit bus at all
      default: misalign = (DATA_W == 32) ? 1'b1 : |mem_addr_i[2:0];
    endcase
  end

  assign accept = (state == ST_IDLE) && valid_i && mem_op && !flush_i && !misalign;

  // In IDLE the aligner sees the incoming op (store lanes); once the
  // access is in flight it sees the captured type/offset (load lanes).
  assign al_type = (state == ST_IDLE) ? data_type_i : dtype;
  assign al_off  = (state == ST_IDLE) ? mem_addr_i[OFF_W-1:0] : off;

  lsu_align #(.DATA_W(DATA_W)) u_align (
    .data_type (al_type),
    .off       (al_off),
    .st_data   (w_mem_data_i),
    .ld_raw    (bus_rdata_i),
    .st_be     (al_be),
    .st_wdata  (al_wdata),
    .ld_data   (al_ld)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      is_load     <= 1'b0;
      load_wb     <= 1'b0;
      err         <= 1'b0;
      rd          <= '0;
      dtype       <= '0;
      off         <= '0;
      ld_result   <= '0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= '0;
      bus_be_o    <= '0;
      bus_wdata_o <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state       <= ST_REQ;
            cnt         <= '0;
            err         <= 1'b0;
            // a store takes precedence if both enables are set
            is_load     <= !w_mem_enable_i;
            load_wb     <= mem_w_reg_enable_i;
            rd          <= w_reg_addr_i;
            dtype       <= data_type_i;
            off         <= mem_addr_i[OFF_W-1:0];
            bus_we_o    <= w_mem_enable_i;
            bus_addr_o  <= {mem_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            bus_be_o    <= w_mem_enable_i ? al_be : '1;
            bus_wdata_o <= w_mem_enable_i ? al_wdata : '0;
          end
        end
        ST_REQ: begin
          if (bus_ack_i) begin
            state     <= ST_DONE;
            err       <= bus_err_i;
            ld_result <= al_ld;
          end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            // this is the TIMEOUT_CYC-th request cycle with no ack
            state <= ST_DONE;
            err   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus_req_o = (state == ST_REQ);

  always_comb begin
    w_reg_enable_o = 1'b0;
    w_reg_addr_o   = w_reg_addr_i;
    w_reg_data_o   = ex_w_reg_data_i;
    stall_o        = 1'b0;
    exc_misalign_o = 1'b0;
    exc_bus_o      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (valid_i && !flush_i) begin
          if (!mem_op)       w_reg_enable_o = ex_w_reg_enable_i;
          else if (misalign) exc_misalign_o = 1'b1;
          else               stall_o        = 1'b1;
        end
      end
      ST_REQ: stall_o = 1'b1;
      ST_DONE: begin
        w_reg_addr_o   = rd;
        w_reg_data_o   = ld_result;
        w_reg_enable_o = is_load && load_wb && !err;
        exc_bus_o      = err;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Parametrised load/store unit for the MEM stage of the core, replacing the pure pass-through MEM stage.
- Adds byte/halfword/word (and doubleword when DATA_W=64) access with byte enables, sign/zero extension of loads, misalignment detection and a req/ack bus handshake with wait states and timeout.
- Drives stall_o to freeze IF..EX while an access is outstanding.
- Non-memory instructions pass through combinationally with zero added latency; CSR write fields stay in the existing pass-through path and are not part of this block.

Parameters:
- DATA_W, 32, bus/register data width; legal values 32 or 64.
- ADDR_W, 32, byte address width.
- TIMEOUT_CYC, 16, maximum cycles bus_req_o may wait for bus_ack_i before the access is aborted; must be >= 2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- valid_i  in  1  instruction present in MEM stage.
- flush_i  in  1  kill the current instruction; has effect only in IDLE (see Behaviour).
- ex_w_reg_enable_i  in  1  ALU result writes rd.
- mem_w_reg_enable_i  in  1  load writes rd.
- w_reg_addr_i  in  5  destination register.
- ex_w_reg_data_i  in  DATA_W  ALU result.
- mem_addr_i  in  ADDR_W  effective byte address.
- r_mem_enable_i  in  1  load.
- w_mem_enable_i  in  1  store.
- w_mem_data_i  in  DATA_W  store data, right-aligned.
- data_type_i  in  4  access type: B, H, W, D, BU, HU, WU.
- bus_req_o  out  1  request, held high until ack.
- bus_we_o  out  1  write request.
- bus_addr_o  out  ADDR_W  address aligned to DATA_W/8 bytes.
- bus_be_o  out  DATA_W/8  byte enables.
- bus_wdata_o  out  DATA_W  lane-replicated store data.
- bus_ack_i  in  1  access complete.
- bus_rdata_i  in  DATA_W  read data, valid with ack.
- bus_err_i  in  1  bus error, valid with ack.
- stall_o  out  1  freeze upstream stages.
- w_reg_enable_o  out  1  write-back enable.
- w_reg_addr_o  out  5  write-back register.
- w_reg_data_o  out  DATA_W  write-back data.
- exc_misalign_o  out  1  one-cycle misaligned-access exception.
- exc_bus_o  out  1  one-cycle bus error or timeout exception.

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE; all registered outputs and the timeout counter cleared; bus_req_o=0. Reset mid-access drops the request immediately and discards the result.
- States: IDLE, REQ, DONE.
- Non-memory op (valid_i=1, no load or store):
  - w_reg_*_o = ex_w_reg_enable_i / w_reg_addr_i / ex_w_reg_data_i combinationally.
  - stall_o=0.
- Memory op in IDLE, aligned, flush_i=0:
  - stall_o=1 combinationally in that cycle; w_reg_enable_o=0.
  - Next state REQ; bus_* outputs registered at this edge.
- Misaligned op (address not a multiple of the access size):
  - No bus request; exc_misalign_o=1 for that cycle; w_reg_enable_o=0; stall_o=0.
  - D-type access with DATA_W=32 is also flagged via exc_misalign_o.
- flush_i in IDLE: the instruction is killed; no request, no write-back, no exceptions.
- REQ:
  - bus_req_o=1 and stall_o=1; bus_addr_o, bus_be_o, bus_wdata_o and bus_we_o are held stable until bus_ack_i.
  - Counter increments each cycle. On ack, capture the result and go to DONE.
  - When the count reaches TIMEOUT_CYC without ack, abort: req drops, error flag is set, go to DONE.
- DONE (one cycle):
  - stall_o=0.
  - Load without error: w_reg_enable_o=1 with the registered extended data.
  - Error or timeout: exc_bus_o=1, w_reg_enable_o=0.
  - Store: w_reg_enable_o=0.
  - Next state IDLE; a new op can be accepted in the following cycle.
- flush_i in REQ/DONE is ignored: the bus protocol forbids retracting a request, and the pipeline is frozen.
- Byte enables, with off = addr mod (DATA_W/8):
  - B: be = 1 << off.
  - H: be = 2'b11 << off.
  - W: be = 4'hF << off.
  - D: all ones.
  - Store data is replicated across every lane of its size.
- Load: select the lane at off, then extend to DATA_W. B/H/W sign-extend; BU/HU/WU zero-extend. Loads drive all-ones be.
- Upstream holds inputs stable while stall_o=1.

Decomposition:
- Add to define.v:
  - data_type encodings.
  - lsu state encodings.
  - `bus_be_bus width macro.
- Sub-module lsu_align: combinational byte-enable/replication for stores and lane select/extension for loads. Reused by a future D-cache.

Test Plan:
- SW 0xDEADBEEF @0x100, ack after 3 wait cycles -> be=4'hF, req high 4 cycles, stall_o high 5 cycles, no reg write.
- SB 0x000000A5 @0x103 -> be=4'b1000, wdata=0xA5A5A5A5. LB @0x103 with rdata=0x80000000 -> rd=0xFFFFFF80. LBU -> rd=0x00000080.
- LH @0x101 -> exc_misalign_o=1 for one cycle, bus_req_o never asserted, stall_o=0.
- LW with no ack, TIMEOUT_CYC=16 -> req drops after 16 cycles, exc_bus_o=1 in DONE, no write-back.
- ADD result 0x1234 valid_i=1 -> w_reg_data_o=0x1234 same cycle, stall_o=0. flush_i with a load in IDLE -> no request, no write-back.
- rst_n low while in REQ -> next cycle bus_req_o=0, state IDLE. DATA_W=64: LD @0x8 -> be=8'hFF, rd=rdata.
